// File: rtl/rf_wb_arbiter.sv
// Two-requester register-file writeback arbiter with a pending-write scoreboard.
// Round-robin grant, one-cycle registered write-out, set-wins reservation tracking.
module rf_wb_arbiter #(
    parameter int WIDTH = 32,
    parameter int ADDR_SPACE = 5,
    parameter int REG_AMOUNT = 32,
    parameter logic [ADDR_SPACE-1:0] ZERO_REGISTER = 5'b00000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    input  logic [ADDR_SPACE-1:0] req0_addr,
    input  logic [WIDTH-1:0]      req0_data,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [ADDR_SPACE-1:0] req1_addr,
    input  logic [WIDTH-1:0]      req1_data,
    output logic                  req1_ready,
    input  logic                  rsv_en,
    input  logic [ADDR_SPACE-1:0] rsv_addr,
    input  logic [ADDR_SPACE-1:0] chk1_addr,
    input  logic [ADDR_SPACE-1:0] chk2_addr,
    output logic                  busy1,
    output logic                  busy2,
    output logic [REG_AMOUNT-1:0] busy_vec,
    output logic                  wr_en,
    output logic [ADDR_SPACE-1:0] wr_addr,
    output logic [WIDTH-1:0]      wr_data
);

    logic                  last_grant;
    logic                  grant0;
    logic                  grant1;
    logic                  xfer;
    logic [ADDR_SPACE-1:0] xfer_addr;
    logic [WIDTH-1:0]      xfer_data;
    logic [REG_AMOUNT-1:0] set_vec;
    logic [REG_AMOUNT-1:0] clr_vec;

    // last_grant = 1 means requester 1 was served last, so requester 0 wins a tie.
    always_comb begin
        grant0 = rst && req0_valid && (!req1_valid || last_grant);
        grant1 = rst && req1_valid && (!req0_valid || !last_grant);
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign xfer       = grant0 || grant1;
    assign xfer_addr  = grant1 ? req1_addr : req0_addr;
    assign xfer_data  = grant1 ? req1_data : req0_data;

    // Address decode only spans tracked registers, so out-of-range addresses never match.
    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        busy1   = 1'b0;
        busy2   = 1'b0;
        for (int i = 0; i < REG_AMOUNT; i++) begin
            if (ADDR_SPACE'(i) != ZERO_REGISTER) begin
                set_vec[i] = rst && rsv_en && (rsv_addr == ADDR_SPACE'(i));
                clr_vec[i] = xfer && (xfer_addr == ADDR_SPACE'(i));
            end
            if (chk1_addr == ADDR_SPACE'(i)) begin
                busy1 = busy_vec[i];
            end
            if (chk2_addr == ADDR_SPACE'(i)) begin
                busy2 = busy_vec[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_vec <= '0;
        end else begin
            busy_vec <= (busy_vec & ~clr_vec) | set_vec;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant <= 1'b1;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
        end else begin
            wr_en <= xfer && (xfer_addr != ZERO_REGISTER);
            if (xfer) begin
                last_grant <= grant1;
                wr_addr    <= xfer_addr;
                wr_data    <= xfer_data;
            end
        end
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed testbench for rf_wb_arbiter with hand-computed expectations.
module tb_rf_wb_arbiter;

    logic        clk;
    logic        rst;
    logic        req0_valid;
    logic [4:0]  req0_addr;
    logic [31:0] req0_data;
    logic        req0_ready;
    logic        req1_valid;
    logic [4:0]  req1_addr;
    logic [31:0] req1_data;
    logic        req1_ready;
    logic        rsv_en;
    logic [4:0]  rsv_addr;
    logic [4:0]  chk1_addr;
    logic [4:0]  chk2_addr;
    logic        busy1;
    logic        busy2;
    logic [31:0] busy_vec;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;

    int n_cmp = 0;
    int n_err = 0;

    rf_wb_arbiter dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .chk1_addr(chk1_addr), .chk2_addr(chk2_addr),
        .busy1(busy1), .busy2(busy2), .busy_vec(busy_vec),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
        req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
        rsv_en = 1'b0; rsv_addr = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        next_cycle();
        idle_inputs();
        rst = 1'b0;
        next_cycle();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        chk1_addr = '0; chk2_addr = '0;
        #2 rst = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        n_cmp++; if (wr_en !== 1'b0) begin $display("FAIL rst_wr_en got %b exp 0", wr_en); n_err++; end
        n_cmp++; if (wr_addr !== 5'd0) begin $display("FAIL rst_wr_addr got %0d exp 0", wr_addr); n_err++; end
        n_cmp++; if (wr_data !== 32'd0) begin $display("FAIL rst_wr_data got %0h exp 0", wr_data); n_err++; end
        n_cmp++; if (busy_vec !== 32'd0) begin $display("FAIL rst_busy_vec got %0h exp 0", busy_vec); n_err++; end
        n_cmp++; if ({req0_ready, req1_ready} !== 2'b00) begin
            $display("FAIL rst_ready got %b exp 00", {req0_ready, req1_ready}); n_err++; end
        next_cycle();
        n_cmp++; if ({req0_ready, req1_ready, wr_en} !== 3'b000) begin
            $display("FAIL rst_ready_after_edge got %b exp 000", {req0_ready, req1_ready, wr_en}); n_err++; end
        idle_inputs();
        rst = 1'b1;
    endtask

    task automatic test_single();
        next_cycle();
        req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'd7;
        #1;
        n_cmp++; if ({req0_ready, req1_ready} !== 2'b10) begin
            $display("FAIL single_ready got %b exp 10", {req0_ready, req1_ready}); n_err++; end
        next_cycle();
        req0_valid = 1'b0;
        n_cmp++; if ({wr_en, wr_addr, wr_data} !== {1'b1, 5'd3, 32'd7}) begin
            $display("FAIL single_write got en=%b addr=%0d data=%0d exp en=1 addr=3 data=7", wr_en, wr_addr, wr_data); n_err++; end
        next_cycle();
        n_cmp++; if ({wr_en, wr_addr, wr_data} !== {1'b0, 5'd3, 32'd7}) begin
            $display("FAIL single_hold got en=%b addr=%0d data=%0d exp en=0 addr=3 data=7", wr_en, wr_addr, wr_data); n_err++; end
        n_cmp++; if (req0_ready !== 1'b0) begin $display("FAIL single_ready_drop got %b exp 0", req0_ready); n_err++; end
    endtask

    task automatic test_contention();
        logic [4:0]  exp_addr;
        logic [31:0] exp_data;
        logic [1:0]  exp_ready;
        pulse_reset();
        req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'h50;
        req1_valid = 1'b1; req1_addr = 5'd6; req1_data = 32'h60;
        for (int k = 0; k < 4; k++) begin
            exp_ready = (k % 2 == 0) ? 2'b10 : 2'b01;
            exp_addr  = (k % 2 == 0) ? 5'd5 : 5'd6;
            exp_data  = (k % 2 == 0) ? 32'h50 : 32'h60;
            #1;
            n_cmp++; if ({req0_ready, req1_ready} !== exp_ready) begin
                $display("FAIL contend_grant%0d got %b exp %b", k, {req0_ready, req1_ready}, exp_ready); n_err++; end
            next_cycle();
            n_cmp++; if ({wr_en, wr_addr, wr_data} !== {1'b1, exp_addr, exp_data}) begin
                $display("FAIL contend_write%0d got en=%b addr=%0d data=%0h exp addr=%0d data=%0h",
                         k, wr_en, wr_addr, wr_data, exp_addr, exp_data); n_err++; end
        end
        // Last grant was req1: a lone req1 still wins, then the next tie goes to req0.
        req0_valid = 1'b0;
        #1;
        n_cmp++; if ({req0_ready, req1_ready} !== 2'b01) begin
            $display("FAIL lone_req1 got %b exp 01", {req0_ready, req1_ready}); n_err++; end
        next_cycle();
        req0_valid = 1'b1;
        #1;
        n_cmp++; if ({req0_ready, req1_ready} !== 2'b10) begin
            $display("FAIL tie_after_req1 got %b exp 10", {req0_ready, req1_ready}); n_err++; end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_scoreboard();
        next_cycle();
        rsv_en = 1'b1; rsv_addr = 5'd7; chk1_addr = 5'd7; chk2_addr = 5'd8;
        #1;
        n_cmp++; if (busy1 !== 1'b0) begin $display("FAIL sb_no_bypass got %b exp 0", busy1); n_err++; end
        next_cycle();
        rsv_en = 1'b0;
        n_cmp++; if ({busy1, busy2, busy_vec} !== {1'b1, 1'b0, 32'h0000_0080}) begin
            $display("FAIL sb_set got busy1=%b busy2=%b vec=%0h exp 1 0 80", busy1, busy2, busy_vec); n_err++; end
        req1_valid = 1'b1; req1_addr = 5'd7; req1_data = 32'h77;
        #1;
        n_cmp++; if ({req1_ready, busy1} !== 2'b11) begin
            $display("FAIL sb_xfer_cycle got ready=%b busy1=%b exp 1 1", req1_ready, busy1); n_err++; end
        next_cycle();
        req1_valid = 1'b0;
        n_cmp++; if ({busy1, wr_en, wr_addr, wr_data} !== {1'b0, 1'b1, 5'd7, 32'h77}) begin
            $display("FAIL sb_clear got busy1=%b en=%b addr=%0d data=%0h exp 0 1 7 77", busy1, wr_en, wr_addr, wr_data); n_err++; end
    endtask

    task automatic test_set_wins();
        next_cycle();
        rsv_en = 1'b1; rsv_addr = 5'd9;
        next_cycle();
        chk2_addr = 5'd9;
        req0_valid = 1'b1; req0_addr = 5'd9; req0_data = 32'h99;
        #1;
        n_cmp++; if ({req0_ready, busy2} !== 2'b11) begin
            $display("FAIL setwin_pre got ready=%b busy2=%b exp 1 1", req0_ready, busy2); n_err++; end
        next_cycle();
        idle_inputs();
        n_cmp++; if ({busy_vec[9], busy2} !== 2'b11) begin
            $display("FAIL setwin_bit got vec9=%b busy2=%b exp 1 1", busy_vec[9], busy2); n_err++; end
        n_cmp++; if ({wr_en, wr_addr, wr_data} !== {1'b1, 5'd9, 32'h99}) begin
            $display("FAIL setwin_write got en=%b addr=%0d data=%0h exp 1 9 99", wr_en, wr_addr, wr_data); n_err++; end
    endtask

    task automatic test_zero_reg();
        next_cycle();
        rsv_en = 1'b1; rsv_addr = 5'd0;
        req1_valid = 1'b1; req1_addr = 5'd0; req1_data = 32'd59;
        chk1_addr = 5'd0;
        #1;
        n_cmp++; if (req1_ready !== 1'b1) begin $display("FAIL zero_ready got %b exp 1", req1_ready); n_err++; end
        next_cycle();
        idle_inputs();
        n_cmp++; if ({busy_vec[0], busy1} !== 2'b00) begin
            $display("FAIL zero_busy got vec0=%b busy1=%b exp 0 0", busy_vec[0], busy1); n_err++; end
        n_cmp++; if ({wr_en, wr_addr, wr_data} !== {1'b0, 5'd0, 32'd59}) begin
            $display("FAIL zero_write got en=%b addr=%0d data=%0d exp 0 0 59", wr_en, wr_addr, wr_data); n_err++; end
    endtask

    task automatic test_async_reset();
        next_cycle();
        req0_valid = 1'b1; req0_addr = 5'd12; req0_data = 32'hAB;
        rsv_en = 1'b1; rsv_addr = 5'd4;
        next_cycle();
        n_cmp++; if ({wr_en, wr_addr, busy_vec[4], busy_vec[9]} !== {1'b1, 5'd12, 1'b1, 1'b1}) begin
            $display("FAIL arst_pre got en=%b addr=%0d vec=%0h exp en=1 addr=12 bits4,9 set", wr_en, wr_addr, busy_vec); n_err++; end
        #2 rst = 1'b0;
        #1;
        n_cmp++; if ({wr_en, wr_addr, wr_data, busy_vec} !== {1'b0, 5'd0, 32'd0, 32'd0}) begin
            $display("FAIL arst_immediate got en=%b addr=%0d data=%0h vec=%0h exp all 0", wr_en, wr_addr, wr_data, busy_vec); n_err++; end
        n_cmp++; if ({req0_ready, req1_ready} !== 2'b00) begin
            $display("FAIL arst_ready got %b exp 00", {req0_ready, req1_ready}); n_err++; end
        next_cycle();
        n_cmp++; if ({wr_en, busy_vec} !== {1'b0, 32'd0}) begin
            $display("FAIL arst_hold got en=%b vec=%0h exp 0 0", wr_en, busy_vec); n_err++; end
        idle_inputs();
        rst = 1'b1;
        next_cycle();
        n_cmp++; if ({wr_en, wr_addr, wr_data, busy_vec} !== {1'b0, 5'd0, 32'd0, 32'd0}) begin
            $display("FAIL arst_release got en=%b addr=%0d data=%0h vec=%0h exp all 0", wr_en, wr_addr, wr_data, busy_vec); n_err++; end
        next_cycle();
        n_cmp++; if (wr_en !== 1'b0) begin $display("FAIL arst_no_write got %b exp 0", wr_en); n_err++; end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_scoreboard();
        test_set_wins();
        test_zero_reg();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got no completion exp finish before 100000");
        $fatal(1);
    end

endmodule

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 Parameters SHALL be:
- WIDTH, default 32, data word width.
- ADDR_SPACE, default 5, register address width.
- REG_AMOUNT, default 32, number of registers tracked.
- ZERO_REGISTER, default 5'b00000, hardwired-zero register address.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, sole clock, rising edge.
- rst, in, 1, asynchronous active-low reset.
- req0_valid, in, 1, requester 0 has a writeback.
- req0_addr, in, ADDR_SPACE, requester 0 destination.
- req0_data, in, WIDTH, requester 0 data.
- req0_ready, out, 1, requester 0 granted this cycle.
- req1_valid, in, 1, requester 1 has a writeback.
- req1_addr, in, ADDR_SPACE, requester 1 destination.
- req1_data, in, WIDTH, requester 1 data.
- req1_ready, out, 1, requester 1 granted this cycle.
- rsv_en, in, 1, reserve a destination at issue.
- rsv_addr, in, ADDR_SPACE, register to reserve.
- chk1_addr, in, ADDR_SPACE, scoreboard lookup port 1.
- chk2_addr, in, ADDR_SPACE, scoreboard lookup port 2.
- busy1, out, 1, chk1_addr has a pending write.
- busy2, out, 1, chk2_addr has a pending write.
- busy_vec, out, REG_AMOUNT, full scoreboard.
- wr_en, out, 1, register file write enable.
- wr_addr, out, ADDR_SPACE, register file write address.
- wr_data, out, WIDTH, register file write data.

Function
REQ-003 A transfer SHALL occur on requester i in a cycle where reqi_valid and reqi_ready are both 1; at most one transfer per cycle.

REQ-004 reqi_ready SHALL be combinational:
- 1 iff reqi_valid is 1 and requester i wins arbitration.
- Never 1 while reqi_valid is 0.

REQ-005 Arbitration SHALL be round-robin with a 1-bit last-grant pointer:
- When only one requester is valid, that requester wins.
- When both are valid, the requester not last granted wins.

REQ-006 The pointer SHALL update only on a transfer, to the transferring requester's index.

REQ-007 Write-out latency SHALL be exactly 1 cycle. A transfer at edge N SHALL drive wr_addr/wr_data = transferred addr/data during cycle N+1.

REQ-008 wr_en SHALL be 1 for exactly that one cycle (N+1), except in the zero-register case (REQ-009).

REQ-009 A transfer with addr == ZERO_REGISTER SHALL complete the handshake and drive wr_en=0 in cycle N+1.

REQ-010 In cycles after no transfer:
- wr_en SHALL be 0.
- wr_addr and wr_data SHALL hold their previous values.

REQ-011 rsv_en=1 at an edge SHALL set busy_vec[rsv_addr]. Reserving ZERO_REGISTER SHALL be ignored.

REQ-012 A transfer at an edge SHALL clear busy_vec[addr] at that same edge.

REQ-013 Reserve and clear on the same address at the same edge SHALL leave the bit set (set wins).

REQ-014 busy_vec[ZERO_REGISTER] SHALL be constant 0.

REQ-015 busy1 = busy_vec[chk1_addr] and busy2 = busy_vec[chk2_addr], combinational from the registered vector; no same-cycle bypass.

REQ-016 Addresses >= REG_AMOUNT SHALL be ignored:
- No scoreboard set or clear.
- busy output reads 0.
- A write-out still occurs if transferred.

REQ-017 A requester SHALL hold valid/addr/data stable until transfer. The arbiter SHALL NOT require this for correctness of its own state.

Reset
REQ-018 rst=0 SHALL immediately, without waiting for clk, force:
- wr_en=0, wr_addr=0, wr_data=0.
- busy_vec=0.
- Pointer = 1, so requester 0 wins the first tie.

REQ-019 While rst=0:
- req0_ready and req1_ready SHALL be 0.
- rsv_en SHALL be ignored.

REQ-020 Reset asserted mid-operation SHALL discard any write-out pending for the next cycle (wr_en stays 0).

REQ-021 Release of rst SHALL be synchronous to clk. Normal operation SHALL begin at the first rising edge after release.

Verification
REQ-022 The bench SHALL cover the following directed scenarios:
- Single requester: req0 valid, addr=3, data=7 -> req0_ready=1 same cycle; next cycle wr_en=1, wr_addr=3, wr_data=7; following cycle wr_en=0.
- Contention: both valid for 4 cycles after reset (addr 5 and 6) -> grants alternate req0, req1, req0, req1; wr_addr sequence 5, 6, 5, 6.
- Scoreboard: rsv_en addr=7 -> busy1=1 with chk1_addr=7 next cycle; req1 writes addr 7 -> busy1=0 the cycle after transfer.
- Set-wins collision: busy_vec[9]=1; same edge has rsv_en addr=9 and a transfer to addr 9 -> busy_vec[9] remains 1 and wr_en=1 with wr_addr=9 next cycle.
- Zero register: rsv_en addr=0 and transfer to addr 0, data=59 -> busy_vec[0]=0, req ready=1, wr_en=0 next cycle.
- Async reset mid-write: transfer at edge N, rst pulled low mid-cycle N+1 -> wr_en, wr_addr, wr_data and busy_vec go to 0 immediately; no write after release.
